vga_timing_gen: RTL and testbench

- Parametrised VGA raster timing generator; next generation of the fixed 640x480 timing inside the current VGA block.
- Resolution, porches, sync polarity and sync-to-pixel pipeline alignment are all parameters.
- Provides a pixel-clock enable, so one fast clk can drive a divided pixel rate.
- Outputs pixel coordinates and strobes for the renderer, plus hs/vs/de delayed to match a PIPE-stage renderer; feeds the top-level uo_out mapping.

---
 rtl/vga_timing_pkg.sv | 21 ++
 rtl/sync_delay_line.sv | 42 ++++
 rtl/vga_timing_gen.sv | 109 ++++++++++
 tb/tb_vga_timing_gen.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480@60 timing constants and sizing helpers
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int cnt_width(input int total);
        return (total <= 2) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - enable-gated 3-bit shift register aligning syncs with the renderer
module sync_delay_line #(
    parameter int         PIPE    = 0,
    parameter logic [2:0] RST_VAL = 3'b000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] din,
    output logic [2:0] dout
);

    if (PIPE == 0) begin : g_bypass
        logic unused_bypass;
        assign unused_bypass = &{1'b0, clk, rst, en};
        assign dout = din;
    end else begin : g_shift
        logic [2:0] stage_q [PIPE];
        logic [2:0] stage_d [PIPE];

        always_comb begin
            for (int i = 0; i < PIPE; i++) begin
                stage_d[i] = stage_q[i];
            end
            if (en) begin
                stage_d[0] = din;
                for (int i = 1; i < PIPE; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            for (int i = 0; i < PIPE; i++) begin
                stage_q[i] <= rst ? RST_VAL : stage_d[i];
            end
        end

        assign dout = stage_q[PIPE-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster counters, strobes and pipeline-aligned syncs
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIPE     = 0,
    parameter int FRAME_W  = 8,
    localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int XW      = cnt_width(H_TOTAL),
    localparam int YW      = cnt_width(V_TOTAL)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic [XW-1:0]      x,
    output logic [YW-1:0]      y,
    output logic               active,
    output logic               line_start,
    output logic               frame_start,
    output logic               hs,
    output logic               vs,
    output logic               de,
    output logic [FRAME_W-1:0] frame_count
);

    if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
        V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0 ||
        FRAME_W <= 0 || PIPE < 0 || PIPE > 7) begin : g_param_check
        $error("vga_timing_gen: illegal timing parameters");
    end

    localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] X_ACT    = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] Y_ACT    = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

    logic [XW-1:0]      x_q, x_d;
    logic [YW-1:0]      y_q, y_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               hs_lvl, vs_lvl;

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        frame_d = frame_q;
        if (en) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                    y_d     = '0;
                    frame_d = frame_q + FRAME_W'(1);
                end else begin
                    y_d = y_q + YW'(1);
                end
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            frame_q <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            frame_q <= frame_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign frame_count = frame_q;
    assign active      = (x_q < X_ACT) && (y_q < Y_ACT);
    assign line_start  = en && (x_q == '0);
    assign frame_start = en && (x_q == '0) && (y_q == '0);

    // Sync levels carry their polarity before the delay line so reset can preload them as inactive.
    assign hs_lvl = ((x_q >= HS_START) && (x_q < HS_END)) ? HS_POL : ~HS_POL;
    assign vs_lvl = ((y_q >= VS_START) && (y_q < VS_END)) ? VS_POL : ~VS_POL;

    sync_delay_line #(
        .PIPE    (PIPE),
        .RST_VAL ({~VS_POL, ~HS_POL, 1'b0})
    ) u_sync_delay (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .din  ({vs_lvl, hs_lvl, active}),
        .dout ({vs, hs, de})
    );

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized scoreboard bench for vga_timing_gen
module tb_vga_timing_gen;

    typedef struct {
        int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, pipe, fw;
        bit hpol, vpol;
    } cfg_t;

    typedef struct {
        int x, y, fc;
        bit act, ls, fs, hs, vs, de;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    logic [3:0] x_a, y_a;
    logic [1:0] fc_a;
    logic       act_a, ls_a, fs_a, hs_a, vs_a, de_a;

    logic [9:0] x_b, y_b;
    logic [7:0] fc_b;
    logic       act_b, ls_b, fs_b, hs_b, vs_b, de_b;

    int   errors = 0;
    int   checks = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b1), .VS_POL(1'b0), .PIPE(3), .FRAME_W(2)
    ) dut_a (
        .clk(clk), .rst(rst), .en(en), .x(x_a), .y(y_a), .active(act_a),
        .line_start(ls_a), .frame_start(fs_a), .hs(hs_a), .vs(vs_a), .de(de_a),
        .frame_count(fc_a)
    );

    vga_timing_gen dut_b (
        .clk(clk), .rst(rst), .en(en), .x(x_b), .y(y_b), .active(act_b),
        .line_start(ls_b), .frame_start(fs_b), .hs(hs_b), .vs(vs_b), .de(de_b),
        .frame_count(fc_b)
    );

    // Reference: raster position is just the count of enabled cycles since reset.
    function automatic exp_t model(cfg_t c, int n, bit en_v);
        exp_t e;
        int   ht, vt, hp, vp, m;
        ht    = c.ha + c.hfp + c.hsw + c.hbp;
        vt    = c.va + c.vfp + c.vsw + c.vbp;
        hp    = n % ht;
        vp    = (n / ht) % vt;
        e.x   = hp;
        e.y   = vp;
        e.fc  = (n / (ht * vt)) % (1 << c.fw);
        e.act = (hp < c.ha) && (vp < c.va);
        e.ls  = en_v && (hp == 0);
        e.fs  = en_v && (hp == 0) && (vp == 0);
        if (n >= c.pipe) begin
            m    = n - c.pipe;
            hp   = m % ht;
            vp   = (m / ht) % vt;
            e.hs = (hp >= c.ha + c.hfp && hp < c.ha + c.hfp + c.hsw) ? c.hpol : !c.hpol;
            e.vs = (vp >= c.va + c.vfp && vp < c.va + c.vfp + c.vsw) ? c.vpol : !c.vpol;
            e.de = (hp < c.ha) && (vp < c.va);
        end else begin
            e.hs = !c.hpol;
            e.vs = !c.vpol;
            e.de = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // Monitor: outputs are stable at the falling edge, between stimulus updates.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                check("a_x", int'(x_a), e.x);
                check("a_y", int'(y_a), e.y);
                check("a_frame_count", int'(fc_a), e.fc);
                check("a_active", int'(act_a), int'(e.act));
                check("a_line_start", int'(ls_a), int'(e.ls));
                check("a_frame_start", int'(fs_a), int'(e.fs));
                check("a_hs", int'(hs_a), int'(e.hs));
                check("a_vs", int'(vs_a), int'(e.vs));
                check("a_de", int'(de_a), int'(e.de));
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                check("b_x", int'(x_b), e.x);
                check("b_y", int'(y_b), e.y);
                check("b_frame_count", int'(fc_b), e.fc);
                check("b_active", int'(act_b), int'(e.act));
                check("b_line_start", int'(ls_b), int'(e.ls));
                check("b_frame_start", int'(fs_b), int'(e.fs));
                check("b_hs", int'(hs_b), int'(e.hs));
                check("b_vs", int'(vs_b), int'(e.vs));
                check("b_de", int'(de_b), int'(e.de));
            end
        end
    end

    initial begin
        cfg_t cfg_a, cfg_b;
        int   n;
        bit   r, e_v;
        cfg_a = '{ha: 8, hfp: 2, hsw: 3, hbp: 3, va: 6, vfp: 1, vsw: 2, vbp: 2,
                  pipe: 3, fw: 2, hpol: 1'b1, vpol: 1'b0};
        cfg_b = '{ha: 640, hfp: 16, hsw: 96, hbp: 48, va: 480, vfp: 10, vsw: 2, vbp: 33,
                  pipe: 0, fw: 8, hpol: 1'b0, vpol: 1'b0};
        rst = 1'b1;
        en  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        n = 0;
        for (int cyc = 0; cyc < 7000; cyc++) begin
            if (cyc < 1500) begin
                e_v = 1'b1;
            end else if (cyc < 3000) begin
                e_v = (cyc % 2) == 0;
            end else begin
                e_v = ($urandom_range(0, 3) != 0);
            end
            r = (cyc == 1 || cyc == 1303 || cyc == 3000) ||
                (cyc > 3000 && $urandom_range(0, 799) == 0);
            rst = r;
            en  = e_v;
            q_a.push_back(model(cfg_a, n, e_v));
            q_b.push_back(model(cfg_b, n, e_v));
            n = r ? 0 : n + int'(e_v);
            @(posedge clk);
            #2;
        end
        rst = 1'b0;
        en  = 1'b0;
        for (int w = 0; w < 10 && (q_a.size() > 0 || q_b.size() > 0); w++) begin
            @(posedge clk);
        end
        if (q_a.size() > 0 || q_b.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d entries left, expected 0", q_a.size() + q_b.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
